// File: rtl/program_loader.sv
// Boot loader: receives a word count and a program over 8N1 UART, writes it into
// the instruction ROM, and releases the CPU reset once the last word has landed.
module program_loader #(
  parameter int CLKS_PER_BIT         = 868,
  parameter int ROM_ADDRESS_BITWIDTH = 15
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            rx,
  output logic                            rom_wren,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                     rom_write_data,
  output logic                            cpu_reset_n,
  output logic                            loading,
  output logic                            error
);
  localparam int AW = ROM_ADDRESS_BITWIDTH;
  localparam int IW = AW - 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [63:0]   CAP  = 64'd1 << (AW - 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_COUNT, LD_DATA, LD_DONE, LD_ERROR} ld_state_e;

  logic rx_meta_q, rx_s_q;
  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic byte_valid, framing_err;

  logic [1:0]  byte_cnt_q;
  logic [23:0] word_q;
  logic [31:0] word;
  logic        word_done;

  ld_state_e ld_state_q, ld_state_d;
  logic [IW-1:0] idx_q, idx_d, n_q, n_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   data_d;
  logic          wren_d, cpu_rst_d, loading_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    byte_valid  = 1'b0;
    framing_err = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d       = '0;
          byte_valid  = rx_s_q;
          framing_err = !rx_s_q;
          rx_state_d  = RX_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
    end
  end

  // Little-endian packing; the 4th byte is taken straight from the shifter.
  assign word      = {shreg_q, word_q};
  assign word_done = byte_valid && (byte_cnt_q == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (byte_valid) begin
      byte_cnt_q <= byte_cnt_q + 1'b1;
      case (byte_cnt_q)
        2'd0:    word_q[7:0]   <= shreg_q;
        2'd1:    word_q[15:8]  <= shreg_q;
        2'd2:    word_q[23:16] <= shreg_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    wren_d     = 1'b0;
    addr_d     = rom_address;
    data_d     = rom_write_data;
    case (ld_state_q)
      LD_COUNT: begin
        if (framing_err) ld_state_d = LD_ERROR;
        else if (word_done) begin
          if (word == 32'd0) ld_state_d = LD_DONE;
          else if ({32'd0, word} > CAP) ld_state_d = LD_ERROR;
          else begin
            n_d        = word[IW-1:0];
            idx_d      = '0;
            ld_state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (framing_err) ld_state_d = LD_ERROR;
        else if (word_done) begin
          wren_d = 1'b1;
          data_d = word;
          addr_d = {idx_q[AW-3:0], 2'b00};
          idx_d  = IW'(idx_q + 1'b1);
          if (idx_d == n_q) ld_state_d = LD_DONE;
        end
      end
      default: ;
    endcase
    // Release one cycle after the last write strobe, or straight away for N = 0.
    cpu_rst_d = (ld_state_d == LD_DONE) && (ld_state_q != LD_DATA);
    loading_d = !cpu_rst_d && (ld_state_d != LD_ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_state_q     <= LD_COUNT;
      idx_q          <= '0;
      n_q            <= '0;
      rom_wren       <= 1'b0;
      rom_address    <= '0;
      rom_write_data <= '0;
      cpu_reset_n    <= 1'b0;
      loading        <= 1'b1;
      error          <= 1'b0;
    end else begin
      ld_state_q     <= ld_state_d;
      idx_q          <= idx_d;
      n_q            <= n_d;
      rom_wren       <= wren_d;
      rom_address    <= addr_d;
      rom_write_data <= data_d;
      cpu_reset_n    <= cpu_rst_d;
      loading        <= loading_d;
      error          <= (ld_state_d == LD_ERROR);
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: UART byte driver, write/reset-edge monitor,
// one task per scenario with inline checks.
module tb_program_loader;
  logic clk = 1'b0, reset_n = 1'b0, rx = 1'b1;
  logic rom_wren, cpu_reset_n, loading, error;
  logic [5:0]  rom_address;
  logic [31:0] rom_write_data;

  program_loader #(.CLKS_PER_BIT(8), .ROM_ADDRESS_BITWIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rom_wren(rom_wren),
    .rom_address(rom_address), .rom_write_data(rom_write_data),
    .cpu_reset_n(cpu_reset_n), .loading(loading), .error(error));

  always #5 clk = ~clk;

  int pass_cnt = 0, tot_cnt = 0;
  int cyc = 0, rise_cyc = -1, lfall_cyc = -1, falls = 0;
  logic prev_rst = 1'b0, prev_ld = 1'b1, rst_at_stop;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rom_wren === 1'b1) begin
      wr_addr.push_back(rom_address);
      wr_data.push_back(rom_write_data);
      wr_cyc.push_back(cyc);
    end
    if (cpu_reset_n === 1'b1 && prev_rst === 1'b0) rise_cyc = cyc;
    if (cpu_reset_n === 1'b0 && prev_rst === 1'b1) falls++;
    if (loading === 1'b0 && prev_ld === 1'b1) lfall_cyc = cyc;
    prev_rst = cpu_reset_n;
    prev_ld  = loading;
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rise_cyc = -1; lfall_cyc = -1; falls = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    repeat (4) @(negedge clk);
  endtask

  // Called at a negedge; each bit is held for 8 clocks.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop;
    rst_at_stop = cpu_reset_n;
    repeat (8) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; rx = 1'b1;
    repeat (2) @(negedge clk);
    tot_cnt++; if (rom_wren !== 1'b0) $display("FAIL rst_wren got %b want 0", rom_wren); else pass_cnt++;
    tot_cnt++; if (rom_address !== 6'd0) $display("FAIL rst_addr got %h want 00", rom_address); else pass_cnt++;
    tot_cnt++; if (rom_write_data !== 32'd0) $display("FAIL rst_data got %h want 0", rom_write_data); else pass_cnt++;
    tot_cnt++; if (cpu_reset_n !== 1'b0) $display("FAIL rst_cpu got %b want 0", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (loading !== 1'b1) $display("FAIL rst_loading got %b want 1", loading); else pass_cnt++;
    tot_cnt++; if (error !== 1'b0) $display("FAIL rst_error got %b want 0", error); else pass_cnt++;
    reset_n = 1'b1;
    clear_log();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_normal();
    do_reset();
    send_word(32'd2);
    send_word(32'h0010_0513);
    send_word(32'h0020_0593);
    repeat (20) @(negedge clk);
    tot_cnt++; if (wr_addr.size() !== 2) $display("FAIL norm_count got %0d want 2", wr_addr.size()); else pass_cnt++;
    if (wr_addr.size() == 2) begin
      tot_cnt++; if (wr_addr[0] !== 6'h00) $display("FAIL norm_addr0 got %h want 00", wr_addr[0]); else pass_cnt++;
      tot_cnt++; if (wr_data[0] !== 32'h0010_0513) $display("FAIL norm_data0 got %h want 00100513", wr_data[0]); else pass_cnt++;
      tot_cnt++; if (wr_addr[1] !== 6'h04) $display("FAIL norm_addr1 got %h want 04", wr_addr[1]); else pass_cnt++;
      tot_cnt++; if (wr_data[1] !== 32'h0020_0593) $display("FAIL norm_data1 got %h want 00200593", wr_data[1]); else pass_cnt++;
      tot_cnt++; if (rise_cyc !== wr_cyc[1] + 1) $display("FAIL norm_release_cyc got %0d want %0d", rise_cyc, wr_cyc[1] + 1); else pass_cnt++;
      tot_cnt++; if (lfall_cyc !== wr_cyc[1] + 1) $display("FAIL norm_loading_cyc got %0d want %0d", lfall_cyc, wr_cyc[1] + 1); else pass_cnt++;
    end
    tot_cnt++; if (cpu_reset_n !== 1'b1) $display("FAIL norm_cpu got %b want 1", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (error !== 1'b0) $display("FAIL norm_error got %b want 0", error); else pass_cnt++;
  endtask

  task automatic test_zero_count();
    do_reset();
    send_word(32'd0);
    tot_cnt++; if (rst_at_stop !== 1'b0) $display("FAIL zero_cpu_early got %b want 0", rst_at_stop); else pass_cnt++;
    tot_cnt++; if (cpu_reset_n !== 1'b1) $display("FAIL zero_cpu got %b want 1", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (loading !== 1'b0) $display("FAIL zero_loading got %b want 0", loading); else pass_cnt++;
    tot_cnt++; if (wr_addr.size() !== 0) $display("FAIL zero_writes got %0d want 0", wr_addr.size()); else pass_cnt++;
  endtask

  task automatic test_oversize();
    do_reset();
    send_word(32'd17);
    send_word(32'hDEAD_BEEF);
    repeat (20) @(negedge clk);
    tot_cnt++; if (error !== 1'b1) $display("FAIL over_error got %b want 1", error); else pass_cnt++;
    tot_cnt++; if (cpu_reset_n !== 1'b0) $display("FAIL over_cpu got %b want 0", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (loading !== 1'b0) $display("FAIL over_loading got %b want 0", loading); else pass_cnt++;
    tot_cnt++; if (wr_addr.size() !== 0) $display("FAIL over_writes got %0d want 0", wr_addr.size()); else pass_cnt++;
  endtask

  task automatic test_full_size();
    do_reset();
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_word(32'hA5C3_0000 + 32'(i * 32'h0101));
    repeat (20) @(negedge clk);
    tot_cnt++; if (wr_addr.size() !== 16) $display("FAIL full_count got %0d want 16", wr_addr.size()); else pass_cnt++;
    for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
      tot_cnt++; if (wr_addr[i] !== 6'(i * 4)) $display("FAIL full_addr%0d got %h want %h", i, wr_addr[i], 6'(i * 4)); else pass_cnt++;
      tot_cnt++; if (wr_data[i] !== 32'hA5C3_0000 + 32'(i * 32'h0101)) $display("FAIL full_data%0d got %h", i, wr_data[i]); else pass_cnt++;
    end
    if (wr_cyc.size() == 16) begin
      tot_cnt++; if (rise_cyc !== wr_cyc[15] + 1) $display("FAIL full_release_cyc got %0d want %0d", rise_cyc, wr_cyc[15] + 1); else pass_cnt++;
    end
    tot_cnt++; if (cpu_reset_n !== 1'b1) $display("FAIL full_cpu got %b want 1", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (error !== 1'b0) $display("FAIL full_error got %b want 0", error); else pass_cnt++;
  endtask

  task automatic test_framing();
    do_reset();
    send_word(32'd2);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    repeat (20) @(negedge clk);
    tot_cnt++; if (error !== 1'b1) $display("FAIL frame_error got %b want 1", error); else pass_cnt++;
    tot_cnt++; if (cpu_reset_n !== 1'b0) $display("FAIL frame_cpu got %b want 0", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (wr_addr.size() !== 0) $display("FAIL frame_writes got %0d want 0", wr_addr.size()); else pass_cnt++;
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    tot_cnt++; if (error !== 1'b0) $display("FAIL glitch_error got %b want 0", error); else pass_cnt++;
    tot_cnt++; if (loading !== 1'b1) $display("FAIL glitch_loading got %b want 1", loading); else pass_cnt++;
    send_word(32'd1);
    send_word(32'h1234_5678);
    repeat (20) @(negedge clk);
    tot_cnt++; if (wr_addr.size() !== 1) $display("FAIL glitch_writes got %0d want 1", wr_addr.size()); else pass_cnt++;
    if (wr_data.size() == 1) begin
      tot_cnt++; if (wr_data[0] !== 32'h1234_5678) $display("FAIL glitch_data got %h want 12345678", wr_data[0]); else pass_cnt++;
    end
    tot_cnt++; if (cpu_reset_n !== 1'b1) $display("FAIL glitch_cpu got %b want 1", cpu_reset_n); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(32'd2);
    send_word(32'hCAFE_F00D);
    send_byte(8'h5A, 1'b1);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    tot_cnt++; if (wr_addr.size() !== 1) $display("FAIL mid_first_write got %0d want 1", wr_addr.size()); else pass_cnt++;
    #3 reset_n = 1'b0;
    #1;
    tot_cnt++; if (rom_write_data !== 32'd0) $display("FAIL mid_data got %h want 0", rom_write_data); else pass_cnt++;
    tot_cnt++; if (rom_wren !== 1'b0) $display("FAIL mid_wren got %b want 0", rom_wren); else pass_cnt++;
    tot_cnt++; if (cpu_reset_n !== 1'b0) $display("FAIL mid_cpu got %b want 0", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (loading !== 1'b1) $display("FAIL mid_loading got %b want 1", loading); else pass_cnt++;
    rx = 1'b1;
    #13 reset_n = 1'b1;
    clear_log();
    repeat (4) @(negedge clk);
    send_word(32'd1);
    send_word(32'hDDCC_BBAA);
    repeat (20) @(negedge clk);
    tot_cnt++; if (wr_addr.size() !== 1) $display("FAIL mid_writes got %0d want 1", wr_addr.size()); else pass_cnt++;
    if (wr_addr.size() == 1) begin
      tot_cnt++; if (wr_addr[0] !== 6'h00) $display("FAIL mid_addr got %h want 00", wr_addr[0]); else pass_cnt++;
      tot_cnt++; if (wr_data[0] !== 32'hDDCC_BBAA) $display("FAIL mid_wdata got %h want DDCCBBAA", wr_data[0]); else pass_cnt++;
    end
    tot_cnt++; if (cpu_reset_n !== 1'b1) $display("FAIL mid_cpu_rel got %b want 1", cpu_reset_n); else pass_cnt++;
  endtask

  // Runs from the released state left by the previous scenario.
  task automatic test_post_done();
    clear_log();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    tot_cnt++; if (wr_addr.size() !== 0) $display("FAIL post_writes got %0d want 0", wr_addr.size()); else pass_cnt++;
    tot_cnt++; if (cpu_reset_n !== 1'b1) $display("FAIL post_cpu got %b want 1", cpu_reset_n); else pass_cnt++;
    tot_cnt++; if (falls !== 0) $display("FAIL post_cpu_drops got %0d want 0", falls); else pass_cnt++;
    tot_cnt++; if (error !== 1'b0) $display("FAIL post_error got %b want 0", error); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_count();
    test_oversize();
    test_full_size();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_post_done();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
